add_and_or: RTL and testbench
=============================

ADD_AND_OR -- requirements
Module: add_and_or

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset, named clk and rst_n.
REQ-002 The module SHALL provide parameter WIDTH, default 64, the operand and result width in bits.
REQ-003 The module SHALL provide port clk, input, 1 bit, the clock; all registers update on its rising edge.
REQ-004 The module SHALL provide port rst_n, input, 1 bit, the asynchronous active-low reset.
REQ-005 The module SHALL provide port in_valid, input, 1 bit, which qualifies the operand and op inputs.
REQ-006 The module SHALL provide port op, input, 4 bits, the operation code: 4'b0000 AND, 4'b0001 OR, 4'b0010 ADD.
REQ-007 The module SHALL provide port rs1, input, WIDTH bits, operand A (two's complement).
REQ-008 The module SHALL provide port rs2, input, WIDTH bits, operand B (two's complement).
REQ-009 The module SHALL provide port cin, input, 1 bit, the carry-in; it is used by ADD only.
REQ-010 The module SHALL provide port rd, output, WIDTH bits, the registered result.
REQ-011 The module SHALL provide port zero, output, 1 bit, set when rd is all zeros for a legal op.
REQ-012 The module SHALL provide port carry, output, 1 bit, the unsigned carry-out of the ADD.
REQ-013 The module SHALL provide port overflow, output, 1 bit, the signed overflow of the ADD.
REQ-014 The module SHALL provide port illegal, output, 1 bit, set when the accepted op is not AND, OR or ADD.
REQ-015 The module SHALL provide port out_valid, output, 1 bit, which qualifies rd, zero, carry, overflow and illegal.

Function
REQ-016 When in_valid=1 at a clock edge, the outputs SHALL present the result on the next edge: latency 1 cycle, out_valid=1 for exactly that cycle, one result per input cycle with no stall.
REQ-017 When in_valid=0, out_valid SHALL be 0 and rd/zero/carry/overflow/illegal SHALL hold their last values.
REQ-018 For ADD: rd = (rs1+rs2+cin) mod 2^WIDTH.
  - carry = bit WIDTH of the full sum.
  - overflow = (rs1[MSB]==rs2[MSB]) && (rd[MSB]!=rs1[MSB]).
REQ-019 For AND: rd = rs1 & rs2. For OR: rd = rs1 | rs2. For both, carry=0 and overflow=0, and cin SHALL be ignored.
REQ-020 zero SHALL be 1 exactly when rd==0 for AND, OR and ADD; this includes the wrap to 0 with carry=1.
REQ-021 For any other op code: rd=0, zero=0, carry=0, overflow=0, illegal=1. For the legal ops, illegal=0.
REQ-022 All arithmetic SHALL be exactly WIDTH bits wide with no saturation; the flags SHALL be computed from the same sum that drives rd.

Reset
REQ-023 When rst_n=0, rd, zero, carry, overflow, illegal and out_valid SHALL clear to 0 immediately, without waiting for a clock edge.
REQ-024 An operation accepted in the cycle of, or the cycle before, reset assertion SHALL be discarded: no out_valid pulse after rst_n is released.
REQ-025 The first operation SHALL be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-026 A shared package SHALL hold the op code constants (OP_AND, OP_OR, OP_ADD) and the default WIDTH.
REQ-027 The module SHALL contain exactly one sub-module, add_core: a combinational WIDTH-bit adder with cin, carry and overflow, built from 4-bit carry-lookahead groups.
REQ-028 The AND/OR logic, result mux, zero detect and output registers SHALL be implemented in add_and_or itself.

Verification
REQ-029 ADD, 5+3, cin=0 -> rd=8, zero=0, carry=0, overflow=0, out_valid one cycle later.
REQ-030 ADD, 0x7FFF_FFFF_FFFF_FFFF + 1 -> rd=0x8000_0000_0000_0000, overflow=1, carry=0, zero=0.
REQ-031 ADD, 0xFFFF_FFFF_FFFF_FFFF + 0, cin=1 -> rd=0, zero=1, carry=1, overflow=0.
REQ-032 AND, 0xF0F0 & 0x0F0F -> rd=0, zero=1. OR with the same operands -> rd=0xFFFF, zero=0. Both with carry=overflow=0, including when cin=1.
REQ-033 op=4'b0011 with in_valid=1 -> rd=0, illegal=1, zero=0. Next cycle with in_valid=0 -> out_valid=0.
REQ-034 Back-to-back ADD ops, then rst_n pulled low mid-cycle -> all outputs 0 immediately, and no out_valid after release until new input.

Source files
------------

// File: rtl/add_and_or_pkg.sv
// Shared constants for the add_and_or datapath: op codes and the default operand width.
package add_and_or_pkg;

  localparam int unsigned DEFAULT_WIDTH = 64;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;

  function automatic logic is_legal_op(input logic [3:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD);
  endfunction

endpackage

// File: rtl/add_and_or_add_core.sv
// Combinational WIDTH-bit adder built from 4-bit carry-lookahead groups rippling group carries.
module add_core import add_and_or_pkg::*; #(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int unsigned NumGroups = (WIDTH + 3) / 4;
  localparam int unsigned PadWidth  = NumGroups * 4;

  logic [PadWidth-1:0]  a_p;
  logic [PadWidth-1:0]  b_p;
  logic [PadWidth-1:0]  sum_p;
  logic [NumGroups:0]   gc;

  assign a_p   = PadWidth'(a);
  assign b_p   = PadWidth'(b);
  assign gc[0] = cin;

  for (genvar grp = 0; grp < NumGroups; grp++) begin : g_cla
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;
    logic       grp_g;
    logic       grp_p;

    assign g = a_p[4*grp +: 4] & b_p[4*grp +: 4];
    assign p = a_p[4*grp +: 4] ^ b_p[4*grp +: 4];

    assign c[0] = gc[grp];
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);

    assign grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    assign grp_p = &p;

    assign gc[grp+1]          = grp_g | (grp_p & c[0]);
    assign sum_p[4*grp +: 4]  = p ^ c;
  end

  assign sum = sum_p[WIDTH-1:0];

  // With zero padding, the padded sum bit at WIDTH is the true carry-out.
  if (PadWidth == WIDTH) begin : g_carry_exact
    assign carry = gc[NumGroups];
  end else begin : g_carry_padded
    assign carry = sum_p[WIDTH];
  end

  assign overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/add_and_or.sv
// Single-cycle AND/OR/ADD unit with registered result, flags and a valid strobe.
module add_and_or import add_and_or_pkg::*; #(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  input  logic             cin,
  output logic [WIDTH-1:0] rd,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             illegal,
  output logic             out_valid
);

  logic [WIDTH-1:0] add_sum;
  logic             add_carry;
  logic             add_overflow;

  logic [WIDTH-1:0] rd_d, rd_q;
  logic             zero_d, zero_q;
  logic             carry_d, carry_q;
  logic             overflow_d, overflow_q;
  logic             illegal_d, illegal_q;
  logic             out_valid_q;

  add_core #(
    .WIDTH (WIDTH)
  ) u_add_core (
    .a        (rs1),
    .b        (rs2),
    .cin      (cin),
    .sum      (add_sum),
    .carry    (add_carry),
    .overflow (add_overflow)
  );

  always_comb begin
    rd_d       = '0;
    carry_d    = 1'b0;
    overflow_d = 1'b0;
    illegal_d  = 1'b0;
    unique case (op)
      OP_AND: rd_d = rs1 & rs2;
      OP_OR:  rd_d = rs1 | rs2;
      OP_ADD: begin
        rd_d       = add_sum;
        carry_d    = add_carry;
        overflow_d = add_overflow;
      end
      default: illegal_d = 1'b1;
    endcase
    // Illegal ops force rd to 0 but must not report zero.
    zero_d = !illegal_d && (rd_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q        <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        rd_q       <= rd_d;
        zero_q     <= zero_d;
        carry_q    <= carry_d;
        overflow_q <= overflow_d;
        illegal_q  <= illegal_d;
      end
    end
  end

  assign rd        = rd_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;
  assign illegal   = illegal_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_add_and_or.sv
// Directed and random checks of add_and_or against an arithmetic reference model.
module tb_add_and_or;

  localparam int W = 64;
  localparam logic signed [65:0] SMAX = 66'sh0_7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [65:0] SMIN = -SMAX - 66'sd1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [3:0]   op = 4'd0;
  logic [W-1:0] rs1 = '0;
  logic [W-1:0] rs2 = '0;
  logic         cin = 1'b0;
  logic [W-1:0] rd;
  logic         zero, carry, overflow, illegal, out_valid;

  int vectors = 0;
  int miscompares = 0;

  // Expected held output state
  logic [W-1:0] e_rd = '0;
  logic e_zero = 0, e_carry = 0, e_ovf = 0, e_ill = 0, e_vld = 0;

  add_and_or #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .op        (op),
    .rs1       (rs1),
    .rs2       (rs2),
    .cin       (cin),
    .rd        (rd),
    .zero      (zero),
    .carry     (carry),
    .overflow  (overflow),
    .illegal   (illegal),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".out_valid"}, W'(out_valid), W'(e_vld));
    check({tag, ".rd"},        rd,            e_rd);
    check({tag, ".zero"},      W'(zero),      W'(e_zero));
    check({tag, ".carry"},     W'(carry),     W'(e_carry));
    check({tag, ".overflow"},  W'(overflow),  W'(e_ovf));
    check({tag, ".illegal"},   W'(illegal),   W'(e_ill));
  endtask

  // Reference: full-precision unsigned and signed sums, range check for overflow.
  task automatic model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c);
    logic [W:0] full;
    logic signed [65:0] s;
    full = {1'b0, a} + {1'b0, b} + (W+1)'(c);
    s = $signed({{2{a[W-1]}}, a}) + $signed({{2{b[W-1]}}, b}) + $signed({65'd0, c});
    e_carry = 0; e_ovf = 0; e_ill = 0;
    case (o)
      4'd0: e_rd = a & b;
      4'd1: e_rd = a | b;
      4'd2: begin
        e_rd    = full[W-1:0];
        e_carry = full[W];
        e_ovf   = (s > SMAX) || (s < SMIN);
      end
      default: begin
        e_rd  = '0;
        e_ill = 1;
      end
    endcase
    e_zero = !e_ill && (e_rd == 0);
  endtask

  task automatic apply(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c, input string tag);
    @(negedge clk);
    in_valid = 1; op = o; rs1 = a; rs2 = b; cin = c;
    @(posedge clk);
    #1;
    model(o, a, b, c);
    e_vld = 1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    @(negedge clk);
    in_valid = 0; op = 4'($urandom); rs1 = {$urandom, $urandom}; rs2 = {$urandom, $urandom};
    cin = 1'($urandom);
    @(posedge clk);
    #1;
    e_vld = 0;
    check_all(tag);
  endtask

  initial begin
    #1;
    check_all("reset");
    #12 rst_n = 1;

    apply(4'd2, 64'd5, 64'd3, 1'b0, "add5p3");
    check("add5p3.rd_const", rd, 64'd8);
    idle("idle1");
    apply(4'd2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, "add_ovf");
    check("add_ovf.ovf_const", W'(overflow), W'(1));
    apply(4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, "add_wrap");
    check("add_wrap.zero_const", W'(zero), W'(1));
    check("add_wrap.carry_const", W'(carry), W'(1));
    apply(4'd0, 64'hF0F0, 64'h0F0F, 1'b1, "and");
    apply(4'd1, 64'hF0F0, 64'h0F0F, 1'b1, "or");
    check("or.rd_const", rd, 64'hFFFF);
    apply(4'd3, 64'hF0F0, 64'h0F0F, 1'b0, "illegal");
    idle("after_illegal");
    apply(4'd2, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, "add_negovf");

    for (int i = 0; i < 300; i++) begin
      logic [W-1:0] a, b;
      logic [3:0] o;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: a = '1;
        1: b = -a;
        2: a = 64'h7FFF_FFFF_FFFF_FFFF;
        default: ;
      endcase
      o = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'($urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) idle("rand_idle");
      else apply(o, a, b, 1'($urandom), "rand");
    end

    // Back-to-back adds, then asynchronous reset mid-cycle with an op still on the inputs
    apply(4'd2, 64'd100, 64'd200, 1'b1, "b2b0");
    apply(4'd2, 64'hFFFF_0000, 64'h0001_0000, 1'b0, "b2b1");
    #2 rst_n = 0;
    #1;
    e_rd = '0; e_zero = 0; e_carry = 0; e_ovf = 0; e_ill = 0; e_vld = 0;
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("in_rst");
    @(negedge clk);
    in_valid = 0;
    rst_n = 1;
    @(posedge clk);
    #1;
    check_all("post_rst1");
    idle("post_rst2");
    apply(4'd2, 64'd1, 64'd1, 1'b0, "first_after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
